// File: rtl/alu_result_display_pkg.sv
// -----------------------------------------------------------------------------
// alu_result_display_pkg
// Shared constants for the calculator result display: converter FSM state
// encoding, operand/BCD widths and active-low 7-segment codes (seg[0]=a ..
// seg[6]=g), plus the double-dabble digit adjust helper.
// -----------------------------------------------------------------------------
package alu_result_display_pkg;

  localparam int NUM_W  = 17;  // ALU result magnitude width
  localparam int BCD_W  = 24;  // six BCD digits
  localparam int DIGITS = 6;
  localparam int SLOTS  = 7;   // six digits plus the sign slot

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Active-low segment codes, bit 0 = segment a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Double-dabble pre-shift correction: any nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_result_display_bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD digit to active-low 7-segment decoder.
//   digit : BCD digit 0..9 (10..15 decode to blank)
//   blank : force all segments off
//   seg   : segments, seg[0]=a .. seg[6]=g, active-low
// -----------------------------------------------------------------------------
module bcd_to_7seg
  import alu_result_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: every signal written in always_comb is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
// Converts the calculator ALU result (17-bit magnitude + sign) to six BCD
// digits with a serial double-dabble converter, then scans the digits and a
// sign slot onto a multiplexed active-low 7-segment display.
//   clk       : system clock, rising edge
//   clear     : synchronous active-high reset
//   number_in : unsigned result magnitude
//   neg_in    : negative-result flag, paired with number_in
//   load      : one-cycle strobe, ignored unless the converter is idle
//   busy      : conversion in progress
//   done      : one-cycle pulse when bcd/neg update
//   bcd, neg  : last completed result (bcd[23:20] most significant)
//   seg, an   : segment data and digit enables (an[6] = sign), active-low
// -----------------------------------------------------------------------------
module alu_result_display
  import alu_result_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [NUM_W-1:0] number_in,
  input  logic             neg_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic             neg,
  output logic [6:0]       seg,
  output logic [6:0]       an
);

  localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // Converter
  // ---------------------------------------------------------------------------
  state_t             state, state_next;
  logic [NUM_W-1:0]   shifter;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [4:0]         bit_cnt;
  logic               sign_lat;

  assign scratch_adj = dabble_adjust(scratch);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (load) state_next = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 5'd1) state_next = ST_DONE;  // 17th shift
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      sign_lat <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_SHIFT);
      done  <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (load) begin
            shifter  <= number_in;
            sign_lat <= neg_in;
            scratch  <= '0;
            bit_cnt  <= 5'(NUM_W);
          end
        end
        ST_SHIFT: begin
          {scratch, shifter} <= {scratch_adj, shifter} << 1;
          bit_cnt            <= bit_cnt - 5'd1;
        end
        ST_DONE: begin
          // Display registers change only here, so the scan never sees
          // partial scratch contents.
          bcd <= scratch;
          neg <= sign_lat;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0]          scan_cnt;
  logic [2:0]                 slot;
  logic [DIGITS-1:0][3:0]     digits;
  logic [DIGITS-1:0]          shown;
  logic [3:0]                 cur_digit;
  logic                       cur_blank;
  logic [6:0]                 dec_seg;
  logic [6:0]                 slot_seg;

  assign digits = bcd;

  // shown[i]: some digit at position i or above is nonzero; digit 0 always lit.
  always_comb begin
    shown             = '0;
    shown[DIGITS-1]   = (digits[DIGITS-1] != 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      shown[i] = shown[i+1] || (digits[i] != 4'd0);
    end
    shown[0] = 1'b1;
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b1;
    if (slot < 3'(DIGITS)) begin
      cur_digit = digits[slot];
      cur_blank = BLANK_LZ && !shown[slot];
    end
  end

  bcd_to_7seg u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  assign slot_seg = (slot == 3'(SLOTS - 1)) ? (neg ? SEG_MINUS : SEG_BLANK) : dec_seg;

  always_ff @(posedge clk) begin
    if (clear) begin
      scan_cnt <= '0;
      slot     <= '0;
      an       <= 7'b1111111;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        slot     <= (slot == 3'(SLOTS - 1)) ? 3'd0 : slot + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      // an/seg are registered from the same slot, so they stay aligned.
      an  <= ~(7'b0000001 << slot);
      seg <= slot_seg;
    end
  end

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per display digit slot (>=2).
REQ-002 Parameter BLANK_LZ, default 1, 1 = blank leading zero digits.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 clear  in  1  reset, synchronous, active-high.
REQ-005 number_in  in  17  unsigned result magnitude from the calculator ALU.
REQ-006 neg_in  in  1  ALU negative-result flag (special_signal), paired with number_in.
REQ-007 load  in  1  one-cycle strobe, number_in/neg_in valid this cycle.
REQ-008 busy  out  1  high while a conversion is in progress.
REQ-009 done  out  1  one-cycle pulse, bcd/neg valid and updated.
REQ-010 bcd  out  24  six BCD digits, bcd[23:20] most significant.
REQ-011 neg  out  1  sign latched with the displayed value.
REQ-012 seg  out  7  segments, seg[0]=a .. seg[6]=g, active-low.
REQ-013 an  out  7  digit enables, an[0..5] = BCD digit 0..5, an[6] = sign, active-low, one-hot-low.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE + load: capture number_in and neg_in, clear 24-bit scratch, bit counter = 17, go to SHIFT, busy=1 next cycle.
REQ-016 SHIFT, each cycle: add 3 to every scratch nibble >=5, then shift {scratch, shifter} left by one, decrement counter; after the 17th shift go to DONE.
REQ-017 DONE: copy scratch to bcd, latched sign to neg, pulse done=1 for one cycle, busy=0, return to IDLE.
REQ-018 Latency: load sampled at edge N -> done high and new bcd visible in cycle N+18; throughput one conversion per 19 cycles.
REQ-019 load while busy=1 or in DONE is ignored, no queuing.
REQ-020 Full-range rule: 17'd131071 maximum converts to 24'h131071, no overflow; 0 converts to 24'h000000.
REQ-021 bcd/neg hold the last completed result until the next DONE; the scan never shows partial scratch.
REQ-022 Scan: free-running counter 0..SCAN_DIV-1; on wrap digit index advances 0,1,..,6,0.
REQ-023 an drives low only the bit of the current index; seg = 7-segment code of the selected BCD digit.
REQ-024 Sign slot (index 6): seg=7'b0111111 ('-') when neg=1, else 7'b1111111.
REQ-025 BLANK_LZ=1: digits above the most significant nonzero digit show 7'b1111111; digit 0 always shown.
REQ-026 BCD values 10..15 (unreachable) decode to blank.

Reset
REQ-027 clear=1 at an edge: state IDLE, busy=0, done=0, bcd=0, neg=0, scratch/counter=0, scan counter=0, index=0.
REQ-028 During clear and in the first cycle after, an=7'b1111111 and seg=7'b1111111.
REQ-029 clear mid-SHIFT aborts the conversion; no done pulse is produced for it.
REQ-030 clear together with load: clear wins, load is dropped.

Structure
REQ-031 Shared calc package holds FSM state encoding, segment constants (blank, minus, digits 0-9) and the 17/24 width constants.
REQ-032 Digit decoder is one combinational sub-module bcd_to_7seg, single instance on the muxed digit.
REQ-033 All outputs registered, no combinational path from inputs to outputs.

Verification
REQ-034 clear, load number_in=17'd12345 neg_in=0 -> busy 17 cycles, done at N+18, bcd=24'h012345, neg=0.
REQ-035 load 17'd131071 -> bcd=24'h131071; then load 17'd0 -> bcd=24'h000000, done once each.
REQ-036 load 17'd7 neg_in=1, SCAN_DIV=4 -> neg=1; an[6] low slot seg=7'b0111111; an[0] slot seg=7'b1111000 ('7'); an[1..5] slots blank.
REQ-037 load 17'd42, then load 17'd99 3 cycles later -> second load ignored, bcd=24'h000042, single done; load 17'd99 after done -> bcd=24'h000099.
REQ-038 load 17'd500, clear on 5th SHIFT cycle -> next cycle busy=0, bcd=0, an=7'b1111111, no done; later load 17'd5 -> bcd=24'h000005.
REQ-039 SCAN_DIV=4 free run -> each an bit low exactly 4 cycles, order 0..6, wrap to 0 after 28 cycles.
